ifetch_queue: RTL and testbench

- Instruction fetch front end that generates the fetch PC and issues requests to a variable-latency instruction memory.
- Buffers returned {PC, instruction} pairs in a small in-order queue that feeds the IF/ID pipeline register through a valid/ready handshake.
- Takes resolved-branch redirects from the EX/MEM stage, flushes the queue, and discards stale in-flight responses.
- Sits between the PC+4 adder / instruction memory and IF/ID; it replaces the free-running PC register.

---
 rtl/ifq_pkg.sv | 13 +
 rtl/ifq_fifo.sv | 60 ++++++
 rtl/ifetch_queue.sv | 140 ++++++++++++++
 tb/tb_ifetch_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and constants for the instruction fetch queue
package ifq_pkg;

  localparam int PC_W = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [5:0] OPC_B = 6'b000101;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - circular synchronous FIFO with flush, occupancy count and a zeroed head when empty
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = pop && !empty;
  // a full queue still accepts when its head leaves in the same cycle
  assign w_push_ok = push && (!w_full || w_pop_ok);
  assign head_data = empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC generator feeding an in-order {pc, instr} queue with redirect flush
// Define IFQ_UNCOND_PREDICT_EN to redirect fetch on enqueued unconditional B instructions.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [CNT_W-1:0]  w_outstanding;
  logic [CNT_W-1:0]  w_q_count;
  logic              w_pc_empty;
  logic              w_q_empty;
  logic [ADDR_W-1:0] w_rsp_pc;
  ifq_entry_t        w_enq_entry;
  ifq_entry_t        w_head;
  logic [SUM_W-1:0]  w_live;
  logic              w_req_fire;
  logic              w_rsp_keep;
  logic              w_rsp_drop;
  logic              w_push;
  logic              w_pred;
  logic [ADDR_W-1:0] w_pred_pc;
  logic              w_retarget;
  logic [ADDR_W-1:0] w_retarget_pc;
  logic [CNT_W-1:0]  w_out_after_rsp;

  // live credit excludes responses already condemned to be dropped
  assign w_live = {1'b0, w_q_count} + {1'b0, w_outstanding} - {1'b0, r_drop_cnt};

  assign imem_req_valid = !reset && !redirect_valid && !w_pred
                          && (w_live < SUM_W'(DEPTH))
                          && (w_outstanding < CNT_W'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_drop      = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_keep      = imem_rsp_valid && (r_drop_cnt == '0);
  assign w_push          = w_rsp_keep && !redirect_valid && !w_pred;
  assign w_out_after_rsp = w_outstanding - CNT_W'(imem_rsp_valid);

  assign w_enq_entry.pc    = PC_W'(w_rsp_pc);
  assign w_enq_entry.instr = imem_rsp_data;

`ifdef IFQ_UNCOND_PREDICT_EN
  logic              r_pred_valid;
  logic [ADDR_W-1:0] r_pred_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_valid <= 1'b0;
      r_pred_pc    <= '0;
    end else begin
      r_pred_valid <= w_push && (imem_rsp_data[31:26] == OPC_B);
      r_pred_pc    <= w_rsp_pc + {{(ADDR_W-28){imem_rsp_data[25]}}, imem_rsp_data[25:0], 2'b00};
    end
  end

  assign w_pred    = r_pred_valid;
  assign w_pred_pc = r_pred_pc;
`else
  assign w_pred    = 1'b0;
  assign w_pred_pc = '0;
`endif

  assign w_retarget    = redirect_valid || w_pred;
  assign w_retarget_pc = redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : w_pred_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (w_retarget) begin
      // no request issues in a retarget cycle, so this is next cycle's outstanding count
      r_fetch_pc <= w_retarget_pc;
      r_drop_cnt <= w_out_after_rsp;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  ifq_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (w_req_fire),
    .push_data (r_fetch_pc),
    .pop       (imem_rsp_valid),
    .head_data (w_rsp_pc),
    .count     (w_outstanding),
    .empty     (w_pc_empty)
  );

  ifq_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_enq_entry),
    .pop       (out_valid && out_ready),
    .head_data (w_head),
    .count     (w_q_count),
    .empty     (w_q_empty)
  );

  assign out_valid = !w_q_empty;
  assign out_pc    = ADDR_W'(w_head.pc);
  assign out_instr = w_head.instr;
  assign busy      = !w_q_empty || !w_pc_empty;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue with an in-order latency memory model
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  logic [63:0] b_addr = '1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] req_log[$];

  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (a == b_addr) return 32'h1400_0004;
    return {8'h13, a[23:0]};
  endfunction

  // memory: accepts at posedge, answers in order lat edges later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
    end else begin
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        req_log.push_back(imem_req_addr);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic apply_reset(input int l, input logic rdy, input logic ordy);
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = rdy;
    out_ready      = ordy;
    lat            = l;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
  endtask

  task automatic test_sequential;
    int base;
    logic [63:0] exp_pc;
    apply_reset(1, 1'b1, 1'b1);
    base = req_log.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_startup: out_valid %b expected 0", out_valid); end
      end else begin
        exp_pc = 64'(4 * (i - 1));
        checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: valid %b pc %h expected 1 %h", i, out_valid, out_pc, exp_pc); end
        checks++; if (out_instr !== {8'h13, exp_pc[23:0]}) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, out_instr, {8'h13, exp_pc[23:0]}); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy[%0d]: got %b expected 1", i, busy); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_log[base + k] !== 64'(4 * k)) begin errors++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", k, req_log[base + k], 64'(4 * k)); end
    end
  endtask

  task automatic test_stall;
    int base;
    int got;
    apply_reset(1, 1'b1, 1'b0);
    base = req_log.size();
    repeat (10) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL stall_head: valid %b pc %h expected 1 0", out_valid, out_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (req_log.size() - base !== 4) begin errors++; $display("FAIL stall_req_count: got %0d expected 4", req_log.size() - base); end
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && got < 5; n++) begin
      if (out_valid) begin
        checks++; if (out_pc !== 64'(4 * got)) begin errors++; $display("FAIL stall_drain[%0d]: got %h expected %h", got, out_pc, 64'(4 * got)); end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL stall_drain_count: got %0d expected 5", got); end
  endtask

  task automatic test_redirect_drop;
    int base;
    int first;
    apply_reset(3, 1'b1, 1'b1);
    base = req_log.size();
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed: got %b expected 0", out_valid); end
    first = -1;
    for (int n = 2; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        first = n;
        break;
      end
    end
    checks++; if (first !== 5) begin errors++; $display("FAIL redir_first_cycle: got %0d expected 5", first); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL redir_first_pc: got %h expected 100", out_pc); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h104) begin errors++; $display("FAIL redir_second_pc: valid %b pc %h expected 1 104", out_valid, out_pc); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h108) begin errors++; $display("FAIL redir_third_pc: valid %b pc %h expected 1 108", out_valid, out_pc); end
    checks++; if (req_log[base + 3] !== 64'h100) begin errors++; $display("FAIL redir_req_addr: got %h expected 100", req_log[base + 3]); end
  endtask

  task automatic test_redirect_collide;
    apply_reset(1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h4) begin errors++; $display("FAIL coll_pre_head: valid %b pc %h expected 1 4", out_valid, out_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1002;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_empty: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b expected 0", busy); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin errors++; $display("FAIL coll_req: valid %b addr %h expected 1 1000", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_no_stale: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin errors++; $display("FAIL coll_first_pc: valid %b pc %h expected 1 1000", out_valid, out_pc); end
  endtask

  task automatic test_async_reset;
    int base;
    apply_reset(2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL areset_pre: valid %b busy %b expected 1 1", out_valid, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL areset_head: pc %h instr %h expected 0 0", out_pc, out_instr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid: got %b expected 0", imem_req_valid); end
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    base      = req_log.size();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL areset_restart: valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC); end
    @(negedge clk);
    checks++; if (req_log.size() <= base || req_log[base] !== RESET_PC) begin errors++; $display("FAIL areset_first_req: log %0d entries, expected first addr %h", req_log.size() - base, RESET_PC); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL areset_first_out: valid %b pc %h expected 1 %h", out_valid, out_pc, RESET_PC); end
  endtask

`ifdef IFQ_UNCOND_PREDICT_EN
  task automatic test_predict;
    logic [63:0] seen[$];
    b_addr = 64'h20;
    apply_reset(1, 1'b1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) seen.push_back(out_pc);
    end
    checks++; if (seen.size() < 3) begin errors++; $display("FAIL pred_count: got %0d expected >= 3", seen.size()); end
    else begin
      checks++; if (seen[0] !== 64'h20) begin errors++; $display("FAIL pred_first: got %h expected 20", seen[0]); end
      checks++; if (seen[1] !== 64'h30) begin errors++; $display("FAIL pred_target: got %h expected 30", seen[1]); end
      checks++; if (seen[2] !== 64'h34) begin errors++; $display("FAIL pred_after: got %h expected 34", seen[2]); end
    end
    foreach (seen[k]) begin
      checks++; if (seen[k] === 64'h24) begin errors++; $display("FAIL pred_shadow[%0d]: got %h expected not 24", k, seen[k]); end
    end
    b_addr = '1;
  endtask
`endif

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_drop;
    test_redirect_collide;
    test_async_reset;
`ifdef IFQ_UNCOND_PREDICT_EN
    test_predict;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
